// File: rtl/imem_fetch_port.sv
// -----------------------------------------------------------------------------
// imem_fetch_port
// Byte-addressed, little-endian instruction memory behind a registered,
// back-pressurable fetch port (valid/ready on both request and response).
// A request accepted in cycle N produces its response in cycle N+1. A held
// response stays bit-stable until the consumer takes it or a flush drops it.
//
// Optional feature (compile-time macro IMEM_LOAD_PORT_EN):
//   defined   : ld_en/ld_addr/ld_data write one byte per cycle into memory
//   undefined : ld_* ports are present but ignored, memory is read-only
//
// Parameters
//   ADDR_W      width of fetch/load byte addresses
//   DEPTH_BYTES memory size in bytes (multiple of 4, >= 16)
//   INIT_FILE   image selector; "" selects the built-in 4-word program
//   CNT_W       width of the saturating accepted-fetch counter
//
// Ports
//   clk, reset               rising-edge clock, async active-low reset
//   req_valid/req_ready      fetch request handshake (req_ready combinational)
//   req_addr                 byte address of the requested instruction
//   flush                    drops a held response, blocks requests this cycle
//   resp_valid/resp_ready    response handshake
//   resp_inst/addr/fault     registered response payload
//   fetch_count              accepted requests since reset (saturating)
//   ld_en/ld_addr/ld_data    program-load byte write port
// -----------------------------------------------------------------------------
module imem_fetch_port #(
  parameter int    ADDR_W      = 64,
  parameter int    DEPTH_BYTES = 256,
  parameter string INIT_FILE   = "",
  parameter int    CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_fault,
  output logic [CNT_W-1:0]  fetch_count,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data
);

  localparam int                IDX_W          = $clog2(DEPTH_BYTES);
  localparam logic [31:0]       NOP_INST       = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] MEM_END_ADDR   = ADDR_W'(DEPTH_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX        = {CNT_W{1'b1}};

  typedef logic [7:0] mem_t [DEPTH_BYTES];

  // Power-up image: the built-in program laid out little-endian,
  // everything else zero. Reset never touches memory.
  function automatic mem_t f_init_image();
    mem_t        m;
    logic [31:0] prog [4];
    prog[0] = 32'h0084_84B3;
    prog[1] = 32'h009A_84B3;
    prog[2] = 32'h0014_8493;
    prog[3] = 32'h0054_8493;
    for (int i = 0; i < DEPTH_BYTES; i++) begin
      m[i] = 8'h00;
    end
    if (INIT_FILE == "") begin
      for (int w = 0; w < 4; w++) begin
        for (int b = 0; b < 4; b++) begin
          m[4*w + b] = prog[w][8*b +: 8];
        end
      end
    end
    return m;
  endfunction

  mem_t r_mem = f_init_image();

  logic              r_resp_valid;
  logic [31:0]       r_resp_inst;
  logic [ADDR_W-1:0] r_resp_addr;
  logic              r_resp_fault;
  logic [CNT_W-1:0]  r_fetch_count;

  logic              w_accept;
  logic              w_fault;
  logic [IDX_W-1:0]  w_base;
  logic [31:0]       w_word;

  // A new request may enter when nothing is held or the held one leaves now.
  assign req_ready = !flush && (!r_resp_valid || resp_ready);
  assign w_accept  = req_valid && req_ready;

  // Fault decode and word assembly; faulting requests never index the array.
  always_comb begin
    w_fault = (req_addr[1:0] != 2'b00) || (req_addr > LAST_WORD_ADDR);
    w_base  = req_addr[IDX_W-1:0];
    if (w_fault) begin
      w_word = NOP_INST;
    end else begin
      w_word = {r_mem[w_base + IDX_W'(3)], r_mem[w_base + IDX_W'(2)],
                r_mem[w_base + IDX_W'(1)], r_mem[w_base]};
    end
  end

  // Response register, valid tracking and saturating accept counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid  <= 1'b0;
      r_resp_inst   <= NOP_INST;
      r_resp_addr   <= {ADDR_W{1'b0}};
      r_resp_fault  <= 1'b0;
      r_fetch_count <= {CNT_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_inst  <= w_word;
        r_resp_addr  <= req_addr;
        r_resp_fault <= w_fault;
      end else if (flush || resp_ready) begin
        r_resp_valid <= 1'b0;
      end else begin
        r_resp_valid <= r_resp_valid;
      end
      if (w_accept && (r_fetch_count != CNT_MAX)) begin
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end else begin
        r_fetch_count <= r_fetch_count;
      end
    end
  end

`ifdef IMEM_LOAD_PORT_EN
  // Program-load byte write; the read above sees the pre-write byte.
  always_ff @(posedge clk) begin
    if (ld_en && (ld_addr < MEM_END_ADDR)) begin
      r_mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end
`else
  logic              w_ld_unused;
  logic [ADDR_W-1:0] w_end_unused;
  assign w_ld_unused  = ^{ld_en, ld_addr, ld_data};
  assign w_end_unused = MEM_END_ADDR;
`endif

  assign resp_valid  = r_resp_valid;
  assign resp_inst   = r_resp_inst;
  assign resp_addr   = r_resp_addr;
  assign resp_fault  = r_resp_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: hand-computed vector table for the directed
// cases, an async-reset-mid-stall sequence, then randomized traffic checked
// against a transaction-level model of the fetch port.
module tb_imem_fetch_port;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [63:0] BIG   = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef IMEM_LOAD_PORT_EN
  localparam logic [31:0] LOAD_EXP = 32'h0010_0513;
  localparam logic [31:0] RBW_EXP  = 32'h0010_05AA;
`else
  localparam logic [31:0] LOAD_EXP = 32'h0000_0000;
  localparam logic [31:0] RBW_EXP  = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [63:0] req_addr = 64'd0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_inst;
  logic [63:0] resp_addr;
  logic        resp_fault;
  logic [31:0] fetch_count;
  logic        ld_en = 1'b0;
  logic [63:0] ld_addr = 64'd0;
  logic [7:0]  ld_data = 8'h00;

  always #5 clk = ~clk;

  imem_fetch_port #(.ADDR_W(64), .DEPTH_BYTES(DEPTH), .INIT_FILE(""), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_addr(resp_addr),
    .resp_fault(resp_fault), .fetch_count(fetch_count), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct {
    logic        v;  logic [63:0] a;  logic fl; logic rr;
    logic        le; logic [63:0] la; logic [7:0] ld;
    logic        er; logic ev; logic [31:0] ei; logic [63:0] ea; logic ef; logic [31:0] ec;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: transaction-level view of the port.
  logic [7:0]  m_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_inst;
  logic [63:0] m_addr;
  logic        m_fault;
  logic [31:0] m_count;

  function automatic vec_t mk(logic v, logic [63:0] a, logic fl, logic rr,
                              logic le, logic [63:0] la, logic [7:0] ld,
                              logic er, logic ev, logic [31:0] ei,
                              logic [63:0] ea, logic ef, logic [31:0] ec);
    vec_t t;
    t.v = v; t.a = a; t.fl = fl; t.rr = rr; t.le = le; t.la = la; t.ld = ld;
    t.er = er; t.ev = ev; t.ei = ei; t.ea = ea; t.ef = ef; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_inst = NOP; m_addr = 64'd0; m_fault = 1'b0; m_count = 32'd0;
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    req_valid = t.v; req_addr = t.a; flush = t.fl; resp_ready = t.rr;
    ld_en = t.le; ld_addr = t.la; ld_data = t.ld;
    #1;
  endtask

  // Advance one clock: model computes the cycle's outcome, then the edge.
  task automatic tick();
    logic acc;
    int   ai;
    acc = req_valid && !flush && (!m_valid || resp_ready);
    if (acc) begin
      m_valid = 1'b1;
      m_addr  = req_addr;
      m_fault = (req_addr % 64'd4 != 64'd0) || (req_addr > 64'(DEPTH - 4));
      if (m_fault) begin
        m_inst = NOP;
      end else begin
        ai = int'(req_addr[15:0]);
        m_inst = {m_mem[ai+3], m_mem[ai+2], m_mem[ai+1], m_mem[ai]};
      end
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end else if (flush || resp_ready) begin
      m_valid = 1'b0;
    end
`ifdef IMEM_LOAD_PORT_EN
    if (ld_en && ld_addr < 64'(DEPTH)) m_mem[int'(ld_addr[15:0])] = ld_data;
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [25];
  vec_t r;

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h0084_84B3; prog[1] = 32'h009A_84B3;
    prog[2] = 32'h0014_8493; prog[3] = 32'h0054_8493;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) m_mem[4*w+b] = 8'(prog[w] >> (8*b));
    model_reset();

    //            v     addr   fl    rr    le    ldaddr  data    rdy   val   inst          raddr  flt   cnt
    tbl[0]  = mk(1'b1, 64'd0,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h008484B3, 64'd0,   1'b0, 32'd1);
    tbl[1]  = mk(1'b1, 64'd4,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h009A84B3, 64'd4,   1'b0, 32'd2);
    tbl[2]  = mk(1'b1, 64'd8,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h00148493, 64'd8,   1'b0, 32'd3);
    tbl[3]  = mk(1'b1, 64'd12,  1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h00548493, 64'd12,  1'b0, 32'd4);
    tbl[4]  = mk(1'b1, 64'd4,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h009A84B3, 64'd4,   1'b0, 32'd5);
    tbl[5]  = mk(1'b1, 64'd8,   1'b0, 1'b0, 1'b0, 64'd0,   8'h00, 1'b0, 1'b1, 32'h009A84B3, 64'd4,   1'b0, 32'd5);
    tbl[6]  = mk(1'b1, 64'd8,   1'b0, 1'b0, 1'b0, 64'd0,   8'h00, 1'b0, 1'b1, 32'h009A84B3, 64'd4,   1'b0, 32'd5);
    tbl[7]  = mk(1'b1, 64'd8,   1'b0, 1'b0, 1'b0, 64'd0,   8'h00, 1'b0, 1'b1, 32'h009A84B3, 64'd4,   1'b0, 32'd5);
    tbl[8]  = mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b0, 32'h009A84B3, 64'd4,   1'b0, 32'd5);
    tbl[9]  = mk(1'b1, 64'd2,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, NOP,          64'd2,   1'b1, 32'd6);
    tbl[10] = mk(1'b1, 64'd256, 1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, NOP,          64'd256, 1'b1, 32'd7);
    tbl[11] = mk(1'b1, 64'd252, 1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h00000000, 64'd252, 1'b0, 32'd8);
    tbl[12] = mk(1'b0, 64'd0,   1'b0, 1'b0, 1'b0, 64'd0,   8'h00, 1'b0, 1'b1, 32'h00000000, 64'd252, 1'b0, 32'd8);
    tbl[13] = mk(1'b1, 64'd0,   1'b1, 1'b0, 1'b0, 64'd0,   8'h00, 1'b0, 1'b0, 32'h00000000, 64'd252, 1'b0, 32'd8);
    tbl[14] = mk(1'b1, BIG,     1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, NOP,          BIG,     1'b1, 32'd9);
    tbl[15] = mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'd16,  8'h13, 1'b1, 1'b0, NOP,          BIG,     1'b1, 32'd9);
    tbl[16] = mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'd17,  8'h05, 1'b1, 1'b0, NOP,          BIG,     1'b1, 32'd9);
    tbl[17] = mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'd18,  8'h10, 1'b1, 1'b0, NOP,          BIG,     1'b1, 32'd9);
    tbl[18] = mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'd19,  8'h00, 1'b1, 1'b0, NOP,          BIG,     1'b1, 32'd9);
    tbl[19] = mk(1'b1, 64'd16,  1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, LOAD_EXP,     64'd16,  1'b0, 32'd10);
    tbl[20] = mk(1'b1, 64'd16,  1'b0, 1'b1, 1'b1, 64'd16,  8'hAA, 1'b1, 1'b1, LOAD_EXP,     64'd16,  1'b0, 32'd11);
    tbl[21] = mk(1'b1, 64'd16,  1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, RBW_EXP,      64'd16,  1'b0, 32'd12);
    tbl[22] = mk(1'b0, 64'd0,   1'b0, 1'b1, 1'b1, 64'd256, 8'hFF, 1'b1, 1'b0, RBW_EXP,      64'd16,  1'b0, 32'd12);
    tbl[23] = mk(1'b1, 64'd0,   1'b0, 1'b1, 1'b0, 64'd0,   8'h00, 1'b1, 1'b1, 32'h008484B3, 64'd0,   1'b0, 32'd13);
    tbl[24] = mk(1'b1, 64'd0,   1'b1, 1'b1, 1'b0, 64'd0,   8'h00, 1'b0, 1'b0, 32'h008484B3, 64'd0,   1'b0, 32'd13);

    // Reset state
    #12;
    chk("rst.valid", 64'(resp_valid), 64'd0);
    chk("rst.inst",  64'(resp_inst),  64'(NOP));
    chk("rst.addr",  resp_addr,       64'd0);
    chk("rst.fault", 64'(resp_fault), 64'd0);
    chk("rst.count", 64'(fetch_count), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i]);
      chk($sformatf("row%0d.ready", i), 64'(req_ready), 64'(tbl[i].er));
      tick();
      chk($sformatf("row%0d.valid", i), 64'(resp_valid), 64'(tbl[i].ev));
      chk($sformatf("row%0d.inst", i),  64'(resp_inst),  64'(tbl[i].ei));
      chk($sformatf("row%0d.addr", i),  resp_addr,       tbl[i].ea);
      chk($sformatf("row%0d.fault", i), 64'(resp_fault), 64'(tbl[i].ef));
      chk($sformatf("row%0d.count", i), 64'(fetch_count), 64'(tbl[i].ec));
    end

    // Async reset while a response is held
    drive(mk(1'b1, 64'd4, 1'b0, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 32'd0));
    tick();
    drive(mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 32'd0));
    tick();
    chk("mrst.held", 64'(resp_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mrst.valid", 64'(resp_valid), 64'd0);
    chk("mrst.inst",  64'(resp_inst),  64'(NOP));
    chk("mrst.count", 64'(fetch_count), 64'd0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    drive(mk(1'b1, 64'd8, 1'b0, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 32'd0));
    chk("mrst.ready", 64'(req_ready), 64'd1);
    tick();
    chk("mrst.v2",    64'(resp_valid), 64'd1);
    chk("mrst.inst2", 64'(resp_inst),  64'h0014_8493);
    chk("mrst.cnt2",  64'(fetch_count), 64'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      r = mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 32'd0);
      r.v  = ($urandom_range(0, 3) != 0);
      r.rr = ($urandom_range(0, 3) != 0);
      r.fl = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       r.a = 64'($urandom_range(0, 63)) * 64'd4;
        1:       r.a = 64'($urandom_range(0, 255));
        2:       r.a = 64'($urandom_range(256, 1023));
        3:       r.a = {32'($urandom), 32'($urandom)};
        default: r.a = 64'($urandom_range(0, 4)) * 64'd4;
      endcase
      r.le = ($urandom_range(0, 5) == 0);
      r.la = 64'($urandom_range(0, 300));
      r.ld = 8'($urandom);
      drive(r);
      chk($sformatf("rnd%0d.ready", c), 64'(req_ready), 64'(!flush && (!m_valid || resp_ready)));
      tick();
      chk($sformatf("rnd%0d.valid", c), 64'(resp_valid), 64'(m_valid));
      if (m_valid) begin
        chk($sformatf("rnd%0d.inst", c),  64'(resp_inst),  64'(m_inst));
        chk($sformatf("rnd%0d.addr", c),  resp_addr,       m_addr);
        chk($sformatf("rnd%0d.fault", c), 64'(resp_fault), 64'(m_fault));
      end
      chk($sformatf("rnd%0d.count", c), 64'(fetch_count), 64'(m_count));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
